lcd_timing_gen: RTL

- Parametrised RGB565 parallel-LCD timing and pattern generator. Successor to the fixed 480x272 colour-bar generator.
- Adds separate sync-pulse widths, selectable sync polarity, fully registered outputs and frame-boundary enable.
- Adds four run-time pattern modes, including an external pixel-stream mode with request/coordinate outputs.
- Sits between the pixel-clock PLL and the LCD pins. It is the sole timing master for the panel.

---
 rtl/lcd_timing_gen_pkg.sv | 39 +++
 rtl/lcd_timing_gen_if.sv | 32 +++
 rtl/lcd_timing_gen_pattern.sv | 39 +++
 rtl/lcd_timing_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// Shared encodings for the LCD timing generator: pattern modes, FSM states
// and the RGB565 colour-bar palette.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_EXT   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Control, pixel-request and panel-pin bundle of the LCD timing generator.
// master = generator side, slave = system/panel side.
interface lcd_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             Enable;
  logic [1:0]       Mode;
  logic [15:0]      SolidColor;
  logic             PixReq;
  logic [CNT_W-1:0] PixX;
  logic [CNT_W-1:0] PixY;
  logic [15:0]      PixData;
  logic             FrameStart;
  logic             LCD_DE;
  logic             LCD_HSYNC;
  logic             LCD_VSYNC;
  logic [4:0]       LCD_R;
  logic [5:0]       LCD_G;
  logic [4:0]       LCD_B;

  modport master (
    input  Enable, Mode, SolidColor, PixData,
    output PixReq, PixX, PixY, FrameStart,
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
  );

  modport slave (
    output Enable, Mode, SolidColor, PixData,
    input  PixReq, PixX, PixY, FrameStart,
    input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
  );
endinterface

// File: rtl/lcd_timing_gen_pattern.sv
// Combinational RGB565 pattern select from active-area coordinates.
// Zero latency; no flow control (external data is taken as presented).
module lcd_pattern_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int V_ACTIVE  = 272,
  parameter int GRID_LOG2 = 4,
  parameter int CNT_W     = 11
) (
  input  mode_e            mode,
  input  logic [CNT_W-1:0] pix_x,
  input  logic [CNT_W-1:0] pix_y,
  input  logic [15:0]      solid_color,
  input  logic [15:0]      ext_data,
  output logic [15:0]      color
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] bar_idx;
  logic             grid_on;

  always_comb begin
    bar_idx = pix_x / CNT_W'(BAR_W);
    grid_on = (pix_x[GRID_LOG2-1:0] == '0) || (pix_y[GRID_LOG2-1:0] == '0) ||
              (pix_x == CNT_W'(H_ACTIVE - 1)) || (pix_y == CNT_W'(V_ACTIVE - 1));
    color   = COL_BLACK;
    case (mode)
      // Columns past the eighth bar (H_ACTIVE not a multiple of 8) stay black.
      MODE_BAR:   color = (bar_idx < CNT_W'(8)) ? bar_color(bar_idx[2:0]) : COL_BLACK;
      MODE_GRID:  color = grid_on ? COL_WHITE : COL_BLACK;
      MODE_SOLID: color = solid_color;
      MODE_EXT:   color = ext_data;
      default:    color = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB565 parallel-LCD timing master: counters, run FSM, sync/DE decode, output regs.
// Panel pins one cycle behind the counters; PixReq/PixX/PixY lead LCD_DE by one cycle.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 4,
  parameter int H_BP      = 43,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 8,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 12,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int GRID_LOG2 = 4,
  parameter int CNT_W     = 11
) (
  input  logic               PixelClk,
  input  logic               RST,
  lcd_timing_gen_if.master   lcd
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  state_e           state;
  state_e           state_nxt;
  mode_e            mode_q;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_end;
  logic             frame_end;
  logic             run;
  logic             load_mode;

  logic             hsync_i;
  logic             vsync_i;
  logic             act_i;
  logic [15:0]      pix_col;

  logic             de_q;
  logic             fs_q;
  logic             hs_q;
  logic             vs_q;
  logic [15:0]      rgb_q;

  assign h_end     = (hcnt == CNT_W'(H_TOTAL - 1));
  assign frame_end = h_end && (vcnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lcd.Enable) state_nxt = RUN;
      RUN:     if (frame_end && !lcd.Enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mode only changes on the edge that starts a frame.
  always_comb begin
    run       = 1'b0;
    load_mode = 1'b0;
    case (state)
      IDLE:    load_mode = lcd.Enable;
      RUN: begin
        run       = 1'b1;
        load_mode = frame_end && lcd.Enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      hcnt   <= '0;
      vcnt   <= '0;
      mode_q <= MODE_BAR;
    end else begin
      if (load_mode) mode_q <= mode_e'(lcd.Mode);
      if (!run || frame_end) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (h_end) begin
        hcnt <= '0;
        vcnt <= vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Decode is gated by run so IDLE (counters parked at 0) shows inactive syncs.
  always_comb begin
    hsync_i = run && (hcnt < CNT_W'(H_SYNC));
    vsync_i = run && (vcnt < CNT_W'(V_SYNC));
    act_i   = run &&
              (hcnt >= CNT_W'(H_ACT_START)) && (hcnt < CNT_W'(H_ACT_END)) &&
              (vcnt >= CNT_W'(V_ACT_START)) && (vcnt < CNT_W'(V_ACT_END));
  end

  assign lcd.PixReq = act_i;
  assign lcd.PixX   = act_i ? (hcnt - CNT_W'(H_ACT_START)) : '0;
  assign lcd.PixY   = act_i ? (vcnt - CNT_W'(V_ACT_START)) : '0;

  lcd_pattern_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .GRID_LOG2 (GRID_LOG2),
    .CNT_W     (CNT_W)
  ) u_pattern (
    .mode        (mode_q),
    .pix_x       (lcd.PixX),
    .pix_y       (lcd.PixY),
    .solid_color (lcd.SolidColor),
    .ext_data    (lcd.PixData),
    .color       (pix_col)
  );

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= '0;
    end else begin
      de_q  <= act_i;
      fs_q  <= run && (hcnt == '0) && (vcnt == '0);
      hs_q  <= hsync_i ? HS_POL : ~HS_POL;
      vs_q  <= vsync_i ? VS_POL : ~VS_POL;
      rgb_q <= act_i ? pix_col : 16'h0000;
    end
  end

  assign lcd.LCD_DE     = de_q;
  assign lcd.FrameStart = fs_q;
  assign lcd.LCD_HSYNC  = hs_q;
  assign lcd.LCD_VSYNC  = vs_q;
  assign lcd.LCD_R      = rgb_q[15:11];
  assign lcd.LCD_G      = rgb_q[10:5];
  assign lcd.LCD_B      = rgb_q[4:0];

endmodule
